// File: rtl/kamus_fetch_queue_if.sv
// kamus_fetch_queue_if: handshake bundle between the fetch queue, the L1I port and the ID stage
//   master: the fetch queue (drives L1I request and the instruction head toward ID)
//   slave : the environment (L1I cache, redirect source, ID stage)
//   l1i_req_o/l1i_addr_o/l1i_gnt_i       request channel to L1I
//   l1i_rvalid_i/l1i_rdata_i             in-order response channel from L1I
//   redirect_i/redirect_addr_i           jump/branch redirect from ID/EX
//   instr_valid_o/instr_ready_i          head handshake toward ID
//   instr_data_o/instr_addr_o            head instruction word and its address
interface kamus_fetch_queue_if;
    logic        l1i_req_o;
    logic [31:0] l1i_addr_o;
    logic        l1i_gnt_i;
    logic        l1i_rvalid_i;
    logic [31:0] l1i_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_addr_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_data_o;
    logic [31:0] instr_addr_o;

    modport master (
        output l1i_req_o, l1i_addr_o, instr_valid_o, instr_data_o, instr_addr_o,
        input  l1i_gnt_i, l1i_rvalid_i, l1i_rdata_i, redirect_i, redirect_addr_i, instr_ready_i
    );

    modport slave (
        input  l1i_req_o, l1i_addr_o, instr_valid_o, instr_data_o, instr_addr_o,
        output l1i_gnt_i, l1i_rvalid_i, l1i_rdata_i, redirect_i, redirect_addr_i, instr_ready_i
    );
endinterface

// File: rtl/kamus_fetch_queue.sv
// kamus_fetch_queue: instruction prefetch queue issuing word fetches to L1I and buffering them for ID
//   clk_i             clock, all state updates on rising edge
//   rst_i             asynchronous active-high reset
//   bus               kamus_fetch_queue_if.master (L1I request/response, redirect, ID head)
//   fetch_stall_cnt_o saturating count of cycles ID was ready but the queue was empty
//                     (present only when KAMUS_FETCH_PERF_EN is defined)
//   Parameters: BOOT_ADDR (PC after reset), DEPTH (queue entries, power of two 2..16)
module kamus_fetch_queue #(
    parameter logic [31:0] BOOT_ADDR = 32'h0,
    parameter int          DEPTH     = 4
) (
    input logic                 clk_i,
    input logic                 rst_i,
    kamus_fetch_queue_if.master bus
`ifdef KAMUS_FETCH_PERF_EN
    ,output logic [31:0]        fetch_stall_cnt_o
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, target;
    logic [CW-1:0] count_q, count_d, outst_q, outst_d, disc_q, disc_d;
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   addr_q [DEPTH];
    logic [CW:0]   occ;
    logic          grant, retire, push, pop, valid;

    // Outstanding requests reserve a queue slot, so every response always finds room.
    assign occ    = {1'b0, count_q} + {1'b0, outst_q};
    assign target = bus.redirect_addr_i & ~32'h3;
    assign valid  = count_q != '0;
    assign grant  = bus.l1i_req_o & bus.l1i_gnt_i;
    // A response with nothing outstanding is stray (e.g. from before reset) and is dropped.
    assign retire = bus.l1i_rvalid_i && outst_q != '0;
    assign push   = retire && disc_q == '0;
    assign pop    = valid & bus.instr_ready_i;

    assign bus.l1i_req_o     = !rst_i && occ < (CW+1)'(DEPTH);
    assign bus.l1i_addr_o    = fetch_pc_q;
    assign bus.instr_valid_o = valid;
    assign bus.instr_data_o  = valid ? data_q[head_q] : '0;
    assign bus.instr_addr_o  = valid ? addr_q[head_q] : '0;

    always_comb begin
        fetch_pc_d = bus.redirect_i ? target : grant ? fetch_pc_q + 32'd4 : fetch_pc_q;
        resp_pc_d  = bus.redirect_i ? target : push ? resp_pc_q + 32'd4 : resp_pc_q;
        outst_d    = outst_q + CW'(grant) - CW'(retire);
        // Everything still in flight after a redirect belongs to the old path.
        disc_d     = bus.redirect_i ? outst_d : disc_q - CW'(retire && disc_q != '0);
        count_d    = bus.redirect_i ? '0 : count_q + CW'(push) - CW'(pop);
        head_d     = bus.redirect_i ? '0 : head_q + AW'(pop);
        tail_d     = bus.redirect_i ? '0 : tail_q + AW'(push);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_pc_q <= BOOT_ADDR;
            resp_pc_q  <= BOOT_ADDR;
            outst_q    <= '0;
            disc_q     <= '0;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            disc_q     <= disc_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    // Payload storage needs no reset: the head is masked while the queue is empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            data_q[tail_q] <= bus.l1i_rdata_i;
            addr_q[tail_q] <= resp_pc_q;
        end
    end

`ifdef KAMUS_FETCH_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            stall_q <= '0;
        else if (bus.instr_ready_i && !valid && stall_q != 32'hFFFF_FFFF)
            stall_q <= stall_q + 32'd1;
    end

    assign fetch_stall_cnt_o = stall_q;
`else
`endif
endmodule

// File: tb/tb_kamus_fetch_queue.sv
// tb_kamus_fetch_queue: directed cycle-by-cycle bench for kamus_fetch_queue (DEPTH=4, BOOT_ADDR=0)
module tb_kamus_fetch_queue;
    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    int   checks = 0;
    int   failures = 0;

    kamus_fetch_queue_if bus();

`ifdef KAMUS_FETCH_PERF_EN
    logic [31:0] stall_cnt;
`endif

    kamus_fetch_queue #(.BOOT_ADDR(32'h0), .DEPTH(4)) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus(bus)
`ifdef KAMUS_FETCH_PERF_EN
        ,.fetch_stall_cnt_o(stall_cnt)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic gnt, input logic rv, input logic [31:0] rd,
                         input logic rdy, input logic red, input logic [31:0] ra);
        bus.l1i_gnt_i       = gnt;
        bus.l1i_rvalid_i    = rv;
        bus.l1i_rdata_i     = rd;
        bus.instr_ready_i   = rdy;
        bus.redirect_i      = red;
        bus.redirect_addr_i = ra;
        #1;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        step();
        step();
        rst_i = 1'b0;
    endtask

    initial begin
        #1 rst_i = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        check("rst_req", bus.l1i_req_o, 0);
        check("rst_addr", bus.l1i_addr_o, 32'h0);
        check("rst_valid", bus.instr_valid_o, 0);
        check("rst_data", bus.instr_data_o, 0);
        check("rst_iaddr", bus.instr_addr_o, 0);

        // streaming: grant every cycle, response one cycle later, ID always ready
        do_reset();
        drive(1, 0, 0, 1, 0, 0);
        check("a_req1", bus.l1i_req_o, 1); check("a_addr1", bus.l1i_addr_o, 32'h0); check("a_v1", bus.instr_valid_o, 0);
        step();
        drive(1, 1, 32'hD0, 1, 0, 0);
        check("a_addr2", bus.l1i_addr_o, 32'h4); check("a_v2", bus.instr_valid_o, 0);
        step();
        drive(1, 1, 32'hD4, 1, 0, 0);
        check("a_v3", bus.instr_valid_o, 1); check("a_ia3", bus.instr_addr_o, 32'h0); check("a_id3", bus.instr_data_o, 32'hD0);
        step();
        drive(1, 1, 32'hD8, 1, 0, 0);
        check("a_ia4", bus.instr_addr_o, 32'h4); check("a_id4", bus.instr_data_o, 32'hD4); check("a_addr4", bus.l1i_addr_o, 32'hC);
        step();
        drive(0, 1, 32'hDC, 1, 0, 0);
        check("a_ia5", bus.instr_addr_o, 32'h8);
        step();
        drive(0, 0, 0, 1, 0, 0);
        check("a_ia6", bus.instr_addr_o, 32'hC); check("a_id6", bus.instr_data_o, 32'hDC);
        step();
        check("a_v7", bus.instr_valid_o, 0); check("a_addr7", bus.l1i_addr_o, 32'h10);

        // ID stalled: exactly four grants fill the queue, then fetch resumes at 0x10
        do_reset();
        drive(1, 0, 0, 0, 0, 0); check("b_req1", bus.l1i_req_o, 1); step();
        drive(1, 1, 32'hB0, 0, 0, 0); check("b_req2", bus.l1i_req_o, 1); step();
        drive(1, 1, 32'hB4, 0, 0, 0); check("b_req3", bus.l1i_req_o, 1); step();
        drive(1, 1, 32'hB8, 0, 0, 0); check("b_req4", bus.l1i_req_o, 1); check("b_addr4", bus.l1i_addr_o, 32'hC); step();
        drive(1, 1, 32'hBC, 0, 0, 0); check("b_req5", bus.l1i_req_o, 0); step();
        drive(1, 0, 0, 0, 0, 0);
        check("b_req6", bus.l1i_req_o, 0); check("b_addr6", bus.l1i_addr_o, 32'h10);
        check("b_v6", bus.instr_valid_o, 1); check("b_ia6", bus.instr_addr_o, 32'h0); check("b_id6", bus.instr_data_o, 32'hB0);
        step();
        drive(0, 0, 0, 1, 0, 0); check("b_req7", bus.l1i_req_o, 0); step();
        drive(1, 0, 0, 1, 0, 0);
        check("b_req8", bus.l1i_req_o, 1); check("b_addr8", bus.l1i_addr_o, 32'h10); check("b_ia8", bus.instr_addr_o, 32'h4);
        step();

        // redirect with two outstanding plus a grant in the redirect cycle: three drops
        do_reset();
        drive(1, 0, 0, 0, 0, 0); step();
        drive(1, 0, 0, 0, 0, 0); step();
        drive(1, 0, 0, 0, 1, 32'h103); check("c_addr3", bus.l1i_addr_o, 32'h8); step();
        drive(0, 1, 32'hE0, 0, 0, 0); check("c_addr4", bus.l1i_addr_o, 32'h100); check("c_v4", bus.instr_valid_o, 0); step();
        drive(0, 1, 32'hE4, 0, 0, 0); check("c_v5", bus.instr_valid_o, 0); step();
        drive(1, 1, 32'hE8, 0, 0, 0); check("c_v6", bus.instr_valid_o, 0); check("c_addr6", bus.l1i_addr_o, 32'h100); step();
        drive(0, 1, 32'hF100, 0, 0, 0); check("c_v7", bus.instr_valid_o, 0); check("c_addr7", bus.l1i_addr_o, 32'h104); step();
        drive(0, 0, 0, 1, 0, 0);
        check("c_v8", bus.instr_valid_o, 1); check("c_ia8", bus.instr_addr_o, 32'h100); check("c_id8", bus.instr_data_o, 32'hF100);
        step();

        // grant withheld: request stable, redirect lands next cycle, back-to-back redirects
        do_reset();
        drive(0, 0, 0, 0, 0, 0); check("d_req1", bus.l1i_req_o, 1); check("d_addr1", bus.l1i_addr_o, 32'h0); step();
        drive(0, 0, 0, 0, 0, 0); check("d_req2", bus.l1i_req_o, 1); check("d_addr2", bus.l1i_addr_o, 32'h0); step();
        drive(0, 0, 0, 0, 1, 32'h200); check("d_req3", bus.l1i_req_o, 1); check("d_addr3", bus.l1i_addr_o, 32'h0); step();
        drive(0, 0, 0, 0, 0, 0); check("d_req4", bus.l1i_req_o, 1); check("d_addr4", bus.l1i_addr_o, 32'h200); step();
        drive(0, 0, 0, 0, 1, 32'h300); check("d_addr5", bus.l1i_addr_o, 32'h200); step();
        drive(0, 0, 0, 0, 1, 32'h406); check("d_addr6", bus.l1i_addr_o, 32'h300); step();
        drive(0, 0, 0, 0, 0, 0); check("d_addr7", bus.l1i_addr_o, 32'h404); step();

        // reset mid-operation with a full occupancy, then stray responses are ignored
        do_reset();
        drive(1, 0, 0, 0, 0, 0); step();
        drive(1, 1, 32'hA0, 0, 0, 0); step();
        drive(1, 1, 32'hA4, 0, 0, 0); step();
        drive(1, 0, 0, 0, 0, 0); check("e_v4", bus.instr_valid_o, 1); check("e_ia4", bus.instr_addr_o, 32'h0); step();
        drive(0, 0, 0, 0, 0, 0); check("e_req5", bus.l1i_req_o, 0);
        rst_i = 1'b1;
        #1;
        check("e_rst_req", bus.l1i_req_o, 0); check("e_rst_addr", bus.l1i_addr_o, 32'h0);
        check("e_rst_v", bus.instr_valid_o, 0); check("e_rst_id", bus.instr_data_o, 0); check("e_rst_ia", bus.instr_addr_o, 0);
        step();
        step();
        rst_i = 1'b0;
        drive(0, 1, 32'hAA, 0, 0, 0); check("e_req1", bus.l1i_req_o, 1); check("e_addr1", bus.l1i_addr_o, 32'h0); step();
        drive(1, 1, 32'hAB, 0, 0, 0); check("e_v2", bus.instr_valid_o, 0); step();
        drive(0, 1, 32'hA000, 0, 0, 0); check("e_v3", bus.instr_valid_o, 0); check("e_addr3", bus.l1i_addr_o, 32'h4); step();
        drive(0, 0, 0, 1, 0, 0);
        check("e_v4b", bus.instr_valid_o, 1); check("e_ia4b", bus.instr_addr_o, 32'h0); check("e_id4b", bus.instr_data_o, 32'hA000);
        step();

`ifdef KAMUS_FETCH_PERF_EN
        rst_i = 1'b1;
        drive(0, 0, 0, 1, 0, 0);
        step();
        step();
        check("f_cnt0", stall_cnt, 0);
        rst_i = 1'b0;
        repeat (10) step();
        check("f_cnt10", stall_cnt, 32'd10);
        drive(0, 0, 0, 0, 0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/kamus_fetch_queue.md
KAMUS_FETCH_QUEUE -- requirements
Module: kamus_fetch_queue

Interface
REQ-001 The module SHALL have parameter BOOT_ADDR, default 32'h0, meaning the PC value after reset.
REQ-002 The module SHALL have parameter DEPTH, default 4, meaning instruction queue entries; legal values are powers of two, 2..16.
REQ-003 The module SHALL use one clock; reset SHALL be asynchronous and active-high.
REQ-004 Port clk_i  in  1  clock; all state updates on its rising edge.
REQ-005 Port rst_i  in  1  asynchronous active-high reset.
REQ-006 Port l1i_req_o  out  1  fetch request to $L1I.
REQ-007 Port l1i_addr_o  out  32  fetch address, always word-aligned.
REQ-008 Port l1i_gnt_i  in  1  request accepted this cycle.
REQ-009 Port l1i_rvalid_i  in  1  response data valid, in request order.
REQ-010 Port l1i_rdata_i  in  32  response instruction word.
REQ-011 Port redirect_i  in  1  jump/branch redirect from ID/EX.
REQ-012 Port redirect_addr_i  in  32  redirect target; bits [1:0] ignored.
REQ-013 Port instr_valid_o  out  1  queue head valid toward ID.
REQ-014 Port instr_ready_i  in  1  ID accepts head.
REQ-015 Port instr_data_o  out  32  head instruction word.
REQ-016 Port instr_addr_o  out  32  head instruction address.

Function
REQ-017 fetch_pc SHALL issue l1i_req_o whenever occupancy (queue count + outstanding) < DEPTH, with l1i_addr_o = fetch_pc.
REQ-018 On l1i_req_o & l1i_gnt_i, fetch_pc SHALL advance by 4 (wrapping at 2^32) and outstanding SHALL increment.
REQ-019 Each l1i_rvalid_i SHALL retire exactly one outstanding request; rvalid with zero outstanding is illegal and SHALL be ignored.
REQ-020 A non-discarded response SHALL be written to the queue tail with address resp_pc, then resp_pc advances by 4; data is visible on instr_*_o the cycle after rvalid (no bypass).
REQ-021 instr_valid_o SHALL equal queue-not-empty; head pops on instr_valid_o & instr_ready_i; push and pop in one cycle SHALL keep count unchanged.
REQ-022 The queue SHALL never overflow: occupancy accounting guarantees every response has a free slot.
REQ-023 On redirect_i, the next cycle SHALL have fetch_pc = resp_pc = {redirect_addr_i[31:2],2'b00}, queue empty, and discard count = outstanding after this cycle's grant/rvalid updates.
REQ-024 While discard count > 0, each rvalid SHALL decrement it and drop the data; queue, resp_pc unchanged.
REQ-025 A grant in the redirect cycle SHALL be for the old address and SHALL be counted into discard; a pop in the redirect cycle SHALL still be honoured toward ID.
REQ-026 l1i_req_o SHALL remain stable (req and addr) until granted unless redirect_i occurs.
REQ-027 Back-to-back redirects SHALL each take effect; the last one defines fetch_pc.

Reset
REQ-028 During rst_i: l1i_req_o=0, l1i_addr_o=BOOT_ADDR, instr_valid_o=0, instr_data_o=0, instr_addr_o=0, fetch_pc=resp_pc=BOOT_ADDR, count=outstanding=discard=0.
REQ-029 Reset asserted mid-operation SHALL abandon all outstanding requests; responses arriving after release and before the first grant SHALL be ignored.
REQ-030 First l1i_req_o SHALL assert in the first cycle after rst_i deasserts.

Configuration
REQ-031 Macro KAMUS_FETCH_PERF_EN: when defined, port fetch_stall_cnt_o (out, 32) SHALL count cycles with instr_ready_i=1 and instr_valid_o=0, saturating at 32'hFFFF_FFFF, reset to 0.
REQ-032 Without KAMUS_FETCH_PERF_EN the port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-033 Reset release, gnt=1 always, rvalid one cycle after grant, ready=1 -> instr_addr_o sequence 0x0,0x4,0x8 on consecutive cycles, first valid at cycle 3.
REQ-034 ready=0, gnt=1, rvalid prompt -> exactly 4 grants then l1i_req_o=0; queue holds 0x0..0xC; raising ready resumes fetch at 0x10.
REQ-035 Two requests outstanding, redirect_i to 0x103 -> both late responses dropped, next fetch address 0x100, first delivered instr_addr_o=0x100.
REQ-036 gnt held low 5 cycles -> l1i_req_o and l1i_addr_o stable throughout; redirect in cycle 3 changes l1i_addr_o next cycle.
REQ-037 Assert rst_i with queue full and 2 outstanding -> outputs at reset values immediately; after release fetch restarts at BOOT_ADDR.
REQ-038 With KAMUS_FETCH_PERF_EN, ready=1 and gnt=0 for 10 cycles after reset -> fetch_stall_cnt_o = 10.
